pipelined_cache_ctrl: RTL and testbench

- Parametrised direct-mapped cache controller between one datapath memory port (instruction or data) and a line-wide backing memory.
- Replaces the fixed-latency pass-through memory-delay path.
- Adds zero-wait hits, write-back or write-through mode, write-allocate, and hit/miss statistics.
- Its CPU side presents a read/write/busy handshake, so one instance serves the IF port and one serves the MEM port.

---
 rtl/pipelined_cache_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pipelined_cache_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cache_ctrl.sv
// Direct-mapped cache controller sitting between one CPU memory port and a
// line-wide backing memory. Hits complete with zero wait states; misses
// optionally write back a dirty victim, then fill the line and replay the
// held request as a hit. WRITE_BACK=0 turns every write hit into a
// write-through of the whole line.
module pipelined_cache_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int WRITE_BACK     = 1
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                cpu_read,
  input  logic                                cpu_write,
  input  logic [WORD_SIZE-1:0]                cpu_address,
  input  logic [WORD_SIZE-1:0]                cpu_wdata,
  output logic [WORD_SIZE-1:0]                cpu_rdata,
  output logic                                cpu_busy,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [WORD_SIZE-1:0]                mem_address,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                                mem_ready,
  output logic [WORD_SIZE-1:0]                hit_count,
  output logic [WORD_SIZE-1:0]                miss_count
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;
  localparam bit WB_EN  = (WRITE_BACK != 0);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;
  localparam logic [1:0] S_WT_WRITE  = 2'd3;

  // Control state (asynchronously reset)
  logic [1:0]           state_q, state_d;
  logic                 miss_pend_q, miss_pend_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     pend_tag_q, pend_tag_d;
  logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;
  logic [WORD_SIZE-1:0] hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0] miss_count_q, miss_count_d;

  // Storage (no reset: only meaningful once the line is valid)
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [TAG_W-1:0]     tag_d  [LINES];
  logic [LINE_W-1:0]    data_q [LINES];
  logic [LINE_W-1:0]    data_d [LINES];

  // Request decode
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-1:0]     req_off;
  logic                 req_any;
  logic                 in_idle;
  logic                 hit;
  logic                 miss;
  logic                 fill_done;
  logic [LINE_W-1:0]    cur_line;

  assign req_tag   = cpu_address[WORD_SIZE-1 -: TAG_W];
  assign req_idx   = cpu_address[OFF_W +: IDX_W];
  assign req_off   = cpu_address[OFF_W-1:0];
  assign req_any   = cpu_read | cpu_write;
  assign in_idle   = (state_q == S_IDLE);
  assign hit       = in_idle && req_any && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss      = in_idle && req_any && !hit;
  assign fill_done = (state_q == S_FILL) && mem_ready;

  // Next-state logic for the FSM, line status bits and statistics
  always_comb begin
    state_d      = state_q;
    miss_pend_d  = miss_pend_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    pend_tag_d   = pend_tag_q;
    pend_idx_d   = pend_idx_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          // The replay of a missed request is its completion, not a new hit.
          if (miss_pend_q) miss_pend_d = 1'b0;
          else             hit_count_d = hit_count_q + WORD_SIZE'(1);
          if (cpu_write) begin
            if (WB_EN) begin
              dirty_d[req_idx] = 1'b1;
            end else begin
              // Latch the line so the write-through survives the CPU moving on.
              state_d    = S_WT_WRITE;
              pend_tag_d = req_tag;
              pend_idx_d = req_idx;
            end
          end
        end else if (miss) begin
          miss_count_d = miss_count_q + WORD_SIZE'(1);
          miss_pend_d  = 1'b1;
          pend_tag_d   = req_tag;
          pend_idx_d   = req_idx;
          if (WB_EN && valid_q[req_idx] && dirty_q[req_idx]) state_d = S_WRITEBACK;
          else                                                state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          dirty_d[pend_idx_q] = 1'b0;
          state_d             = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          valid_d[pend_idx_q] = 1'b1;
          dirty_d[pend_idx_q] = 1'b0;
          state_d             = S_IDLE;
        end
      end
      S_WT_WRITE: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset abandons any transfer in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      miss_pend_q  <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      pend_tag_q   <= '0;
      pend_idx_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_pend_q  <= miss_pend_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      pend_tag_q   <= pend_tag_d;
      pend_idx_q   <= pend_idx_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next contents of tag and data arrays: store-word on write hit, full line on fill
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (hit && cpu_write) begin
      data_d[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE] = cpu_wdata;
    end
    if (fill_done) begin
      data_d[pend_idx_q] = mem_rdata;
      tag_d[pend_idx_q]  = pend_tag_q;
    end
  end

  // Tag and data arrays
  always_ff @(posedge Clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  // Zero-wait load data straight out of the array on a read hit
  always_comb begin
    cur_line  = data_q[req_idx];
    cpu_rdata = '0;
    if (hit && !cpu_write) begin
      cpu_rdata = cur_line[int'(req_off)*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Backing-memory request signals derived from the FSM state
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state_q)
      S_WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {tag_q[pend_idx_q], pend_idx_q, {OFF_W{1'b0}}};
        mem_wdata   = data_q[pend_idx_q];
      end
      S_FILL: begin
        mem_read    = 1'b1;
        mem_address = {pend_tag_q, pend_idx_q, {OFF_W{1'b0}}};
      end
      S_WT_WRITE: begin
        mem_write   = 1'b1;
        mem_address = {pend_tag_q, pend_idx_q, {OFF_W{1'b0}}};
        mem_wdata   = data_q[pend_idx_q];
      end
      default: ;
    endcase
  end

  assign cpu_busy   = !in_idle || (req_any && !hit);
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_pipelined_cache_ctrl.sv
// Bench for pipelined_cache_ctrl: one write-back and one write-through
// instance, checked against a transparent-memory model (the cache must
// always return the most recently written value) plus a record of which
// line each index holds.
module tb_pipelined_cache_ctrl;
  localparam int W   = 16;
  localparam int WPL = 4;
  localparam int NL  = 4;
  localparam int LW  = W * WPL;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read    [2];
  logic          cpu_write   [2];
  logic [W-1:0]  cpu_address [2];
  logic [W-1:0]  cpu_wdata   [2];
  logic [W-1:0]  cpu_rdata   [2];
  logic          cpu_busy    [2];
  logic          mem_read    [2];
  logic          mem_write   [2];
  logic [W-1:0]  mem_address [2];
  logic [LW-1:0] mem_wdata   [2];
  logic [LW-1:0] mem_rdata   [2];
  logic          mem_ready   [2];
  logic [W-1:0]  hit_count   [2];
  logic [W-1:0]  miss_count  [2];

  always #5 clk = ~clk;

  pipelined_cache_ctrl #(.WORD_SIZE(W), .LINES(NL), .WORDS_PER_LINE(WPL), .WRITE_BACK(1)) dut_wb (
    .Clk(clk), .Reset(rst),
    .cpu_read(cpu_read[0]), .cpu_write(cpu_write[0]), .cpu_address(cpu_address[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_busy(cpu_busy[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .hit_count(hit_count[0]), .miss_count(miss_count[0]));

  pipelined_cache_ctrl #(.WORD_SIZE(W), .LINES(NL), .WORDS_PER_LINE(WPL), .WRITE_BACK(0)) dut_wt (
    .Clk(clk), .Reset(rst),
    .cpu_read(cpu_read[1]), .cpu_write(cpu_write[1]), .cpu_address(cpu_address[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_busy(cpu_busy[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .hit_count(hit_count[1]), .miss_count(miss_count[1]));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [W-1:0] backing [int];   // contents of the backing memory
  logic [W-1:0] shadow  [int];   // what the CPU must observe
  bit           res_valid [2][NL];
  bit           res_dirty [2][NL];
  int           res_line  [2][NL];
  logic [W-1:0] exp_hits  [2];
  logic [W-1:0] exp_miss  [2];
  bit           wb_mode   [2];

  function automatic logic [W-1:0] init_word(int u, int a);
    return W'(((a * 37) + (u * 11)) ^ 16'hA5C3);
  endfunction

  function automatic logic [W-1:0] bk(int u, int a);
    int k = u * 65536 + a;
    if (backing.exists(k)) return backing[k];
    return init_word(u, a);
  endfunction

  function automatic logic [W-1:0] sh(int u, int a);
    int k = u * 65536 + a;
    if (shadow.exists(k)) return shadow[k];
    return bk(u, a);
  endfunction

  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      exp_hits[u] = '0;
      exp_miss[u] = '0;
      for (int i = 0; i < NL; i++) begin
        res_valid[u][i] = 1'b0;
        res_dirty[u][i] = 1'b0;
        res_line[u][i]  = 0;
      end
    end
    shadow.delete();   // dirty data held only in the cache is lost
  endtask

  // Serve one backing-memory transfer; entered and left at negedge+1.
  task automatic phase(int u, bit is_wr, int line_addr, int dly);
    logic [LW-1:0] ln;
    chk("ph_mem_read", LW'(mem_read[u]), LW'(!is_wr));
    chk("ph_mem_write", LW'(mem_write[u]), LW'(is_wr));
    chk("ph_mem_addr", LW'(mem_address[u]), LW'(line_addr));
    chk("ph_busy", LW'(cpu_busy[u]), 1);
    if (is_wr) begin
      for (int k = 0; k < WPL; k++) begin
        chk("ph_wdata", LW'(mem_wdata[u][k*W +: W]), LW'(sh(u, line_addr + k)));
        backing[u * 65536 + line_addr + k] = sh(u, line_addr + k);
      end
    end
    repeat (dly) begin
      @(negedge clk); #1;
      chk("ph_hold", LW'({mem_read[u], mem_write[u]}), is_wr ? 2'b01 : 2'b10);
      chk("ph_hold_busy", LW'(cpu_busy[u]), 1);
    end
    for (int k = 0; k < WPL; k++) ln[k*W +: W] = bk(u, line_addr + k);
    mem_rdata[u] = is_wr ? '0 : ln;
    mem_ready[u] = 1'b1;
    @(negedge clk);
    mem_ready[u] = 1'b0;
    mem_rdata[u] = '0;
    #1;
  endtask

  // One CPU request, held while busy, with model prediction of every transfer.
  task automatic xact(int u, bit rd, bit wr, logic [W-1:0] a, logic [W-1:0] wd, int dly);
    int  line;
    int  idx;
    bit  hit;
    bit  evict;
    @(negedge clk);
    cpu_read[u]    = rd;
    cpu_write[u]   = wr;
    cpu_address[u] = a;
    cpu_wdata[u]   = wd;
    #1;
    line = int'(a) & ~(WPL - 1);
    idx  = (int'(a) / WPL) % NL;
    hit  = res_valid[u][idx] && (res_line[u][idx] == line);
    chk("req_busy", LW'(cpu_busy[u]), LW'(!hit));
    if (!hit) begin
      exp_miss[u] = exp_miss[u] + 1'b1;
      evict = wb_mode[u] && res_valid[u][idx] && res_dirty[u][idx];
      @(negedge clk); #1;
      if (evict) begin
        phase(u, 1'b1, res_line[u][idx], dly);
        res_dirty[u][idx] = 1'b0;
      end
      phase(u, 1'b0, line, dly);
      res_valid[u][idx] = 1'b1;
      res_line[u][idx]  = line;
      res_dirty[u][idx] = 1'b0;
      chk("replay_busy", LW'(cpu_busy[u]), 0);
    end else begin
      exp_hits[u] = exp_hits[u] + 1'b1;
    end
    if (wr) begin
      shadow[u * 65536 + int'(a)] = wd;
      if (wb_mode[u]) res_dirty[u][idx] = 1'b1;
    end else begin
      chk("rdata", LW'(cpu_rdata[u]), LW'(sh(u, int'(a))));
    end
    @(negedge clk);
    cpu_read[u]  = 1'b0;
    cpu_write[u] = 1'b0;
    #1;
    if (wr && !wb_mode[u]) phase(u, 1'b1, line, dly);
    chk("hit_count", LW'(hit_count[u]), LW'(exp_hits[u]));
    chk("miss_count", LW'(miss_count[u]), LW'(exp_miss[u]));
    chk("idle_busy", LW'(cpu_busy[u]), 0);
    chk("idle_mem", LW'({mem_read[u], mem_write[u]}), 0);
  endtask

  initial begin
    wb_mode[0] = 1'b1;
    wb_mode[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cpu_read[u] = 1'b0; cpu_write[u] = 1'b0; cpu_address[u] = '0;
      cpu_wdata[u] = '0; mem_rdata[u] = '0; mem_ready[u] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_hits", LW'(hit_count[u]), 0);
      chk("rst_miss", LW'(miss_count[u]), 0);
      chk("rst_mem", LW'({mem_read[u], mem_write[u]}), 0);
      chk("rst_busy", LW'(cpu_busy[u]), 0);
      chk("rst_rdata", LW'(cpu_rdata[u]), 0);
    end
    rst = 1'b0;

    // Cold read miss with a known word, then a same-line hit
    backing[0 * 65536 + 5] = 16'hBEEF;
    xact(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2);
    chk("cold_value", LW'(sh(0, 5)), 16'hBEEF);
    xact(0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1);

    // Read+write together acts as a write, then verify, then dirty eviction
    xact(0, 1'b1, 1'b1, 16'h0005, 16'h1234, 0);
    xact(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    xact(0, 1'b1, 1'b0, 16'h0045, 16'h0000, 2);
    xact(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1);

    // Write-through: fill, write hit, conflict miss with no writeback
    xact(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1);
    xact(1, 1'b0, 1'b1, 16'h0005, 16'h4321, 2);
    xact(1, 1'b1, 1'b0, 16'h0045, 16'h0000, 0);
    xact(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 0);

    // Stray mem_ready while idle is ignored
    @(negedge clk);
    mem_ready[0] = 1'b1;
    @(negedge clk);
    mem_ready[0] = 1'b0;
    #1;
    chk("stray_mem", LW'({mem_read[0], mem_write[0]}), 0);
    chk("stray_busy", LW'(cpu_busy[0]), 0);
    chk("stray_hits", LW'(hit_count[0]), LW'(exp_hits[0]));
    chk("stray_miss", LW'(miss_count[0]), LW'(exp_miss[0]));

    // Reset in the middle of a fill
    @(negedge clk);
    cpu_read[0]    = 1'b1;
    cpu_address[0] = 16'h0085;
    @(negedge clk); #1;
    chk("pre_rst_fill", LW'(mem_read[0]), 1);
    rst = 1'b1;
    #1;
    chk("rst_fill_read", LW'(mem_read[0]), 0);
    chk("rst_fill_hits", LW'(hit_count[0]), 0);
    chk("rst_fill_miss", LW'(miss_count[0]), 0);
    chk("rst_wt_hits", LW'(hit_count[1]), 0);
    @(negedge clk);
    cpu_read[0] = 1'b0;
    rst = 1'b0;
    model_reset();
    xact(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1);
    xact(0, 1'b1, 1'b0, 16'h0085, 16'h0000, 0);

    // Randomised traffic on both instances
    for (int i = 0; i < 300; i++) begin
      int u;
      int op;
      u  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      xact(u, op != 1, op == 1 || op == 2, W'($urandom_range(0, 127)), W'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
